// File: rtl/acq_wnd_pkg.sv
// acq_wnd_pkg: shared state encoding and constants for the ACQ_WND train generator
package acq_wnd_pkg;
  localparam int DATABUS_WIDTH_DEF = 32;
  localparam int MIN_LOW_GAP = 2;
  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DELAY  = 4'b0010,
    WND_HI = 4'b0100,
    WND_LO = 4'b1000
  } state_t;
endpackage

// File: rtl/wnd_down_counter.sv
// wnd_down_counter: loadable down-counter with zero flag
module wnd_down_counter #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RESET_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] load_val,
  output logic          zero
);
  logic [DW-1:0] count;
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= count - 1'b1;
  assign zero = (count == '0);
endmodule

// File: rtl/acq_wnd_train_gen.sv
// acq_wnd_train_gen: echo-train acquisition window generator; WND_TRAIN_CONT_EN enables continuous trains
module acq_wnd_train_gen
  import acq_wnd_pkg::*;
#(
  parameter int DATABUS_WIDTH = DATABUS_WIDTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET_n,
  input  logic                     START,
  input  logic                     ABORT,
  input  logic [DATABUS_WIDTH-1:0] INIT_DELAY,
  input  logic [DATABUS_WIDTH-1:0] WND_LEN,
  input  logic [DATABUS_WIDTH-1:0] ECHO_PERIOD,
  input  logic [DATABUS_WIDTH-1:0] NUM_ECHOES,
  output logic                     ACQ_WND,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     CFG_ERR,
  output logic [DATABUS_WIDTH-1:0] ECHO_IDX
);
  localparam int DW = DATABUS_WIDTH;
`ifdef WND_TRAIN_CONT_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif
  state_t state;
  logic [DW-1:0] wnd_len_r, gap_r, ph_val;
  logic cont_r, valid, accept, last, ph_zero, echo_zero, ph_load, ph_en, echo_en;
  assign valid = (WND_LEN != '0) &&
                 ({1'b0, ECHO_PERIOD} >= {1'b0, WND_LEN} + (DW+1)'(MIN_LOW_GAP)) &&
                 ((NUM_ECHOES != '0) || CONT_EN);
  assign accept = (state == IDLE) && START && !ABORT && valid;
  assign last = echo_zero && !cont_r;
  assign ph_load = accept || (!ABORT && ph_zero && state != IDLE && !(state == WND_HI && last));
  assign ph_val = (state == IDLE) ? INIT_DELAY : (state == WND_HI) ? gap_r - 1'b1 : wnd_len_r - 1'b1;
  assign ph_en = (state != IDLE);
  assign echo_en = (state == WND_HI) && ph_zero && !last && !ABORT;
  wnd_down_counter #(.DW(DW)) u_phase (
    .CLK(CLK), .RESET_n(RESET_n), .load(ph_load), .en(ph_en), .load_val(ph_val), .zero(ph_zero)
  );
  wnd_down_counter #(.DW(DW)) u_echo (
    .CLK(CLK), .RESET_n(RESET_n), .load(accept), .en(echo_en),
    .load_val(NUM_ECHOES - 1'b1), .zero(echo_zero)
  );
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      state     <= IDLE;
      ACQ_WND   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      CFG_ERR   <= 1'b0;
      ECHO_IDX  <= '0;
      wnd_len_r <= '0;
      gap_r     <= '0;
      cont_r    <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      CFG_ERR <= 1'b0;
      if (ABORT && state != IDLE) begin
        state   <= IDLE;
        ACQ_WND <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        unique case (state)
          IDLE:
            if (accept) begin
              state     <= DELAY;
              BUSY      <= 1'b1;
              ECHO_IDX  <= '0;
              wnd_len_r <= WND_LEN;
              gap_r     <= ECHO_PERIOD - WND_LEN;
              cont_r    <= CONT_EN && (NUM_ECHOES == '0);
            end else CFG_ERR <= START && !ABORT && !valid;
          DELAY:
            if (ph_zero) begin
              state   <= WND_HI;
              ACQ_WND <= 1'b1;
            end
          WND_HI:
            if (ph_zero) begin
              ACQ_WND <= 1'b0;
              state   <= last ? IDLE : WND_LO;
              BUSY    <= !last;
              DONE    <= last;
            end
          WND_LO:
            if (ph_zero) begin
              state    <= WND_HI;
              ACQ_WND  <= 1'b1;
              ECHO_IDX <= ECHO_IDX + 1'b1;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule
